// File: rtl/vic_nch.sv
// rtl/vic_nch.sv - N-channel vectored interrupt controller for the VM1 bus
//
// Latches rising edges on per-channel request lines, raises VIRQ while any
// enabled channel is pending, and answers the interrupt-acknowledge read
// with the vector of the highest-priority pending channel (channel N-1 is
// highest). The served channel gets a one-clk_sys acknowledge pulse.
//
// Optional feature: define VIC_MASK_EN to add the mask_i port (per-channel
// enable). Without it every channel is always enabled.
//
// Ports:
//   clk_sys  system clock
//   rst_n    asynchronous active-low reset
//   ce       bus clock enable; the acknowledge FSM only moves when ce=1
//   ivec     vector table, channel k at [k*VW +: VW]
//   ireq     per-channel request lines, rising-edge sensitive
//   iack     one-clk_sys pulse when channel k's vector has been delivered
//   irq_o    VIRQ to the CPU
//   stb_i    IAK read strobe
//   ack_o    RPLY for the IAK cycle
//   dat_o    vector data, zero while ack_o=0 (wired-OR bus)
//   mask_i   channel enable, 1=enabled (VIC_MASK_EN only)
module vic_nch #(
  parameter int             N    = 4,
  parameter int             VW   = 16,
  parameter logic [VW-1:0]  SPUR = '0
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic            ce,
  input  logic [N*VW-1:0] ivec,
  input  logic [N-1:0]    ireq,
  output logic [N-1:0]    iack,
  output logic            irq_o,
  input  logic            stb_i,
  output logic            ack_o,
  output logic [VW-1:0]   dat_o
`ifdef VIC_MASK_EN
  ,
  input  logic [N-1:0]    mask_i
`endif
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    en;
  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    ireq_q;
  logic [N-1:0]    act;
  logic [N-1:0]    clr;
  logic [N-1:0]    iack_q;
  logic            irq_q;
  logic [SW-1:0]   sel_q;
  logic            hit_q;
  logic [VW-1:0]   vec_q;
  logic [SW-1:0]   win;
  logic [VW-1:0]   win_vec;
  logic            valid;
  logic            take;

`ifdef VIC_MASK_EN
  assign en = mask_i;
`else
  assign en = '1;
`endif

  assign act = pend_q & en;

  // Fixed priority: the loop runs upward so the highest active index wins.
  always_comb begin
    win     = '0;
    win_vec = '0;
    for (int k = 0; k < N; k++) begin
      if (act[k]) begin
        win     = SW'(k);
        win_vec = ivec[k*VW +: VW];
      end
    end
  end

  assign valid = |act;

  // The IDLE->ACK step freezes the selection; later edges wait for the next IAK.
  assign take = (state_q == ST_IDLE) && ce && stb_i;

  always_comb begin
    state_d = state_q;
    if (ce) begin
      case (state_q)
        ST_IDLE: if (stb_i)  state_d = ST_ACK;
        ST_ACK:              state_d = ST_HOLD;
        ST_HOLD: if (!stb_i) state_d = ST_IDLE;
        default:             state_d = ST_IDLE;
      endcase
    end
  end

  // The served channel is released on the single ce edge that leaves ACK.
  always_comb begin
    clr = '0;
    if ((state_q == ST_ACK) && ce && hit_q) begin
      for (int k = 0; k < N; k++) begin
        clr[k] = (sel_q == SW'(k));
      end
    end
  end

  // Set is ORed in after the clear so a same-cycle new edge is never lost.
  assign pend_d = (pend_q & ~clr) | (ireq & ~ireq_q);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ireq_q  <= '0;
      iack_q  <= '0;
      irq_q   <= 1'b0;
      sel_q   <= '0;
      hit_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ireq_q  <= ireq;
      iack_q  <= clr;
      irq_q   <= valid;
      if (take) begin
        sel_q <= win;
        hit_q <= valid;
        vec_q <= valid ? win_vec : SPUR;
      end
    end
  end

  assign iack  = iack_q;
  assign irq_o = irq_q;
  assign ack_o = (state_q != ST_IDLE);
  assign dat_o = ack_o ? vec_q : '0;

endmodule
